// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit register bank with clock enable, eight
// modes (hold/shl/shr/rol/ror/load/asr/clear) and a saturating shift count.
// Ports: clock, reset (sync, active-high), enable, mode[2:0], data_in,
//   serial_in_l (MSB side, SHR), serial_in_r (LSB side, SHL),
//   data_out, serial_out_l/serial_out_r (data_out MSB/LSB),
//   shift_count (shifts since last load/clear/reset), count_done.
// Optional macro USR_PARITY_EN adds registered parity_out (^data_out).
module universal_shift_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CW          = $clog2(WIDTH+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out_l,
  output logic             serial_out_r,
  output logic [CW-1:0]    shift_count,
`ifdef USR_PARITY_EN
  output logic             parity_out,
`endif
  output logic             count_done
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHL   = 3'b001,
    M_SHR   = 3'b010,
    M_ROL   = 3'b011,
    M_ROR   = 3'b100,
    M_LOAD  = 3'b101,
    M_ASR   = 3'b110,
    M_CLEAR = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_nxt;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_nxt;
  logic             is_shift;
  logic             cnt_clr;
  logic [CW-1:0]    cnt_inc;
  mode_e            op;

  assign op = mode_e'(mode);

  // Saturates at WIDTH so count_done stays high until load/clear/reset.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    data_nxt = data_q;
    is_shift = 1'b0;
    cnt_clr  = 1'b0;
    unique case (op)
      M_HOLD: begin
        data_nxt = data_q;
      end
      M_SHL: begin
        data_nxt = {data_q[WIDTH-2:0], serial_in_r};
        is_shift = 1'b1;
      end
      M_SHR: begin
        data_nxt = {serial_in_l, data_q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      M_ROL: begin
        data_nxt = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        is_shift = 1'b1;
      end
      M_ROR: begin
        data_nxt = {data_q[0], data_q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      M_LOAD: begin
        data_nxt = data_in;
        cnt_clr  = 1'b1;
      end
      M_ASR: begin
        data_nxt = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      M_CLEAR: begin
        data_nxt = RESET_VALUE;
        cnt_clr  = 1'b1;
      end
      default: begin
        data_nxt = data_q;
      end
    endcase
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (cnt_clr) begin
      cnt_nxt = '0;
    end else if (is_shift) begin
      cnt_nxt = cnt_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= RESET_VALUE;
      cnt_q  <= '0;
    end else if (enable) begin
      data_q <= data_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

`ifdef USR_PARITY_EN
  logic parity_q;

  // Registered from the next value so it tracks data_out on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_q <= ^RESET_VALUE;
    end else if (enable) begin
      parity_q <= ^data_nxt;
    end
  end

  assign parity_out = parity_q;
`endif

  assign data_out     = data_q;
  assign serial_out_l = data_q[WIDTH-1];
  assign serial_out_r = data_q[0];
  assign shift_count  = cnt_q;
  assign count_done   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed plus randomized checks of
// universal_shift_reg (WIDTH=8) against an arithmetic reference model.
module tb_universal_shift_reg;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [2:0]   mode;
  logic [W-1:0] data_in;
  logic         serial_in_l;
  logic         serial_in_r;
  logic [W-1:0] data_out;
  logic         serial_out_l;
  logic         serial_out_r;
  logic [3:0]   shift_count;
  logic         count_done;
`ifdef USR_PARITY_EN
  logic         parity_out;
`endif

  int checks = 0;
  int errors = 0;

  int mv = 0;
  int mc = 0;

  universal_shift_reg #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .mode         (mode),
    .data_in      (data_in),
    .serial_in_l  (serial_in_l),
    .serial_in_r  (serial_in_r),
    .data_out     (data_out),
    .serial_out_l (serial_out_l),
    .serial_out_r (serial_out_r),
    .shift_count  (shift_count),
`ifdef USR_PARITY_EN
    .parity_out   (parity_out),
`endif
    .count_done   (count_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: register as an integer 0..255, ops as arithmetic.
  task automatic model(input logic r, e, input logic [2:0] m,
                       input int d, input int sl, input int sr);
    if (r) begin
      mv = 0;
      mc = 0;
    end else if (e) begin
      case (m)
        3'd1: mv = (mv * 2 + sr) % 256;
        3'd2: mv = mv / 2 + sl * 128;
        3'd3: mv = (mv * 2) % 256 + mv / 128;
        3'd4: mv = mv / 2 + (mv % 2) * 128;
        3'd5: mv = d;
        3'd6: mv = mv / 2 + (mv / 128) * 128;
        3'd7: mv = 0;
        default: ;
      endcase
      if (m == 3'd5 || m == 3'd7) mc = 0;
      else if (m != 3'd0 && mc < W) mc = mc + 1;
    end
  endtask

  task automatic step(input logic r, e, input logic [2:0] m,
                      input logic [7:0] d, input logic sl, sr);
    int ones;
    reset = r; enable = e; mode = m;
    data_in = d; serial_in_l = sl; serial_in_r = sr;
    model(r, e, m, int'(d), int'(sl), int'(sr));
    @(posedge clock);
    #1;
    chk("data_out", 64'(data_out), 64'(mv));
    chk("shift_count", 64'(shift_count), 64'(mc));
    chk("count_done", 64'(count_done), 64'(mc == W));
    chk("serial_out_l", 64'(serial_out_l), 64'(mv / 128));
    chk("serial_out_r", 64'(serial_out_r), 64'(mv % 2));
`ifdef USR_PARITY_EN
    ones = 0;
    for (int b = 0; b < W; b++) ones += (mv >> b) & 1;
    chk("parity_out", 64'(parity_out), 64'(ones % 2));
`else
    ones = 0;
`endif
  endtask

  initial begin
    logic [7:0] seq;
    reset = 1'b1; enable = 1'b1; mode = 3'd5;
    data_in = 8'hFF; serial_in_l = 1'b0; serial_in_r = 1'b0;

    // Reset beats enable+LOAD, then hold with enable low.
    step(1, 1, 3'd5, 8'hFF, 0, 0);
    step(1, 1, 3'd5, 8'hFF, 0, 0);
    chk("rst_data", 64'(data_out), 64'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 3'd5, 8'hFF, 1, 1);
    chk("hold_data", 64'(data_out), 64'h00);

    // Serialise A5 MSB first.
    step(0, 1, 3'd5, 8'hA5, 0, 0);
    seq = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("ser_bit", 64'(serial_out_l), 64'(seq[7-i]));
      chk("done_early", 64'(count_done), 64'(0));
      step(0, 1, 3'd1, 8'h00, 1, 0);
    end
    chk("ser_final", 64'(data_out), 64'h00);
    chk("ser_done", 64'(count_done), 64'(1));
    step(0, 1, 3'd1, 8'h00, 0, 0);
    chk("sat_count", 64'(shift_count), 64'd8);

    // Rotate identity.
    step(0, 1, 3'd5, 8'h81, 0, 0);
    step(0, 1, 3'd4, 8'h00, 0, 0);
    chk("ror_first", 64'(data_out), 64'hC0);
    for (int i = 0; i < 7; i++) step(0, 1, 3'd4, 8'h00, 1, 1);
    chk("ror_ident", 64'(data_out), 64'h81);
    chk("ror_done", 64'(count_done), 64'(1));

    // Arithmetic shift and serial-in.
    step(0, 1, 3'd5, 8'h90, 0, 0);
    step(0, 1, 3'd6, 8'h00, 0, 1);
    step(0, 1, 3'd6, 8'h00, 0, 1);
    chk("asr2", 64'(data_out), 64'hE4);
    step(0, 1, 3'd5, 8'h01, 0, 0);
    step(0, 1, 3'd2, 8'h00, 1, 1);
    chk("shr_in", 64'(data_out), 64'h80);

    // Reset mid-operation, then CLEAR after 5 shifts.
    step(0, 1, 3'd5, 8'h3C, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd1, 8'h00, 0, 1);
    step(1, 0, 3'd1, 8'h00, 0, 1);
    chk("mid_rst_data", 64'(data_out), 64'h00);
    chk("mid_rst_cnt", 64'(shift_count), 64'd0);
    chk("mid_rst_done", 64'(count_done), 64'(0));
    step(0, 1, 3'd5, 8'h3C, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 3'd3, 8'h00, 0, 0);
    step(0, 1, 3'd7, 8'hAA, 0, 0);
    chk("clr_data", 64'(data_out), 64'h00);
    chk("clr_cnt", 64'(shift_count), 64'd0);

    // Parity example.
    step(0, 1, 3'd5, 8'h07, 0, 0);
`ifdef USR_PARITY_EN
    chk("par_07", 64'(parity_out), 64'(1));
`endif
    step(0, 1, 3'd1, 8'h00, 0, 1);
    chk("shl_0f", 64'(data_out), 64'h0F);
`ifdef USR_PARITY_EN
    chk("par_0f", 64'(parity_out), 64'(0));
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0),
           ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)),
           8'($urandom),
           1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the single-bit synchronous-reset D flip-flop: a WIDTH-bit register bank with clock enable and eight operating modes.
- Modes: hold, shift, rotate, arithmetic shift, parallel load, clear.
- Tracks shifts since the last load, so it serves both as a general pipeline register and as a parallel-to-serial / serial-to-parallel converter in lab datapaths.

Parameters:
WIDTH, 8, register width in bits; legal range 2..64.
RESET_VALUE, {WIDTH{1'b0}}, value loaded into data_out on reset and on CLEAR.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
enable  input  1  clock enable; low = all state held.
mode  input  3  operation select (encoding below).
data_in  input  WIDTH  parallel load data.
serial_in_l  input  1  bit entering at MSB on SHR.
serial_in_r  input  1  bit entering at LSB on SHL.
data_out  output  WIDTH  register contents.
serial_out_l  output  1  data_out[WIDTH-1], combinational.
serial_out_r  output  1  data_out[0], combinational.
shift_count  output  $clog2(WIDTH+1)  shift/rotate ops since last load/clear/reset, saturating.
count_done  output  1  high when shift_count == WIDTH.

Behaviour:
- All state updates on the rising clock edge only; no asynchronous paths.
- Priority: reset > enable low > mode.
- Reset sampled high: data_out=RESET_VALUE, shift_count=0, count_done=0, regardless of enable/mode.
- enable low: data_out and shift_count hold; inputs ignored.
- enable high, mode encoding, result visible one cycle after the sampling edge (latency 1):
  000 HOLD: no change; count unchanged.
  001 SHL: data_out <= {data_out[WIDTH-2:0], serial_in_r}.
  010 SHR: data_out <= {serial_in_l, data_out[WIDTH-1:1]}.
  011 ROL: data_out <= {data_out[WIDTH-2:0], data_out[WIDTH-1]}.
  100 ROR: data_out <= {data_out[0], data_out[WIDTH-1:1]}.
  101 LOAD: data_out <= data_in; shift_count <= 0.
  110 ASR: data_out <= {data_out[WIDTH-1], data_out[WIDTH-1:1]}; serial_in_l ignored.
  111 CLEAR: data_out <= RESET_VALUE; shift_count <= 0.
- Modes 001/010/011/100/110 increment shift_count by 1, saturating at WIDTH; no wrap to 0.
- count_done is combinational from shift_count. It stays high until LOAD, CLEAR or reset.
- Serialiser use: LOAD, then WIDTH SHL cycles. serial_out_l presents the MSB-first bits. count_done rises on the cycle after the WIDTH-th shift edge.
- Rotating WIDTH times restores the original value; count_done=1.
- Reset asserted mid-sequence: the next edge reinitialises everything, including a saturated counter.
- Reset and enable low together: reset wins.
- No X propagation from unused serial inputs: SHL ignores serial_in_l; SHR ignores serial_in_r.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined: extra output port parity_out (1 bit, registered), equal to even parity (XOR reduction) of the value data_out takes on the same edge.
  - Reset/CLEAR: parity_out = ^RESET_VALUE.
  - Holds whenever data_out holds.
- Undefined: port and logic absent; the rest of the interface and timing is identical.

Test Plan (WIDTH=8, RESET_VALUE=0):
- Reset and hold: reset=1 for 2 edges with enable=1, mode=LOAD, data_in=8'hFF -> data_out=8'h00, shift_count=0. Then reset=0, enable=0 for 3 edges -> data_out stays 8'h00.
- Load/serialise: LOAD 8'hA5, then 8 SHL with serial_in_r=0 -> serial_out_l sequence 1,0,1,0,0,1,0,1; final data_out=8'h00, count_done=1. A 9th SHL -> shift_count stays 8.
- Rotate identity: LOAD 8'h81, 8 ROR -> data_out=8'h81 after the 8th edge; after the first ROR, data_out=8'hC0.
- Arithmetic/serial-in: LOAD 8'h90, ASR x2 -> 8'hE4. LOAD 8'h01, SHR with serial_in_l=1 -> 8'h80.
- Reset mid-operation: LOAD 8'h3C, 3 SHL, reset=1 with mode=SHL -> data_out=8'h00, shift_count=0, count_done=0. CLEAR after 5 shifts -> same result.
- USR_PARITY_EN: LOAD 8'h07 -> parity_out=1. SHL with serial_in_r=1 -> 8'h0F, parity_out=0.
